demux2x4_unstripe: RTL and testbench

Receive-side counterpart of the 4-to-2 lane mux in the PCIe physical-layer datapath. It takes a 2-lane byte stream, 8 bits per lane with per-lane valids, and pairs consecutive beats back into a registered 4-lane word. An idle-timeout flush releases a half-filled word, so trailing data is never stranded. It sits between the 2-lane link-side path and the 4-lane core-side logic, and is checked against the mux in a loopback bench.

---
 rtl/demux2x4_unstripe.sv | 134 +++++++++++++
 tb/tb_demux2x4_unstripe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux2x4_unstripe.sv
// demux2x4_unstripe: receive-side unstriper. Pairs consecutive 2-lane beats
// into a registered 4-lane word. A half-filled word is flushed after IDLE_MAX
// consecutive idle cycles so trailing data is never stranded.
//
// Handshake: there is no backpressure. A beat is any cycle with validin != 0
// and is always consumed on the rising edge that samples it. validout is
// nonzero for exactly one cycle per emitted word. Lanes whose valid bit is 0
// carry zero data. The pending output is the FSM state (1 = HALF).
module demux2x4_unstripe #(
   parameter int WIDTH    = 8,
   parameter int IDLE_MAX = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [1:0]       validin,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [3:0]       validout,
   output logic             pending
);

   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } state_t;

   // The timeout fires when the count of idles already seen in HALF equals
   // IDLE_MAX-1, i.e. on the IDLE_MAX-th idle edge.
   localparam logic [3:0] IDLE_LAST = 4'(IDLE_MAX - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold0_q, hold0_d;
   logic [WIDTH-1:0] hold1_q, hold1_d;
   logic [1:0]       vhold_q, vhold_d;
   logic [3:0]       idle_cnt_q, idle_cnt_d;
   logic [WIDTH-1:0] out0_q, out0_d;
   logic [WIDTH-1:0] out1_q, out1_d;
   logic [WIDTH-1:0] out2_q, out2_d;
   logic [WIDTH-1:0] out3_q, out3_d;
   logic [3:0]       validout_q, validout_d;

   logic beat;
   assign beat = |validin;

   // Next-state and output word computation; validout defaults to 0 so a
   // word is announced for exactly one cycle.
   always_comb begin
      state_d    = state_q;
      hold0_d    = hold0_q;
      hold1_d    = hold1_q;
      vhold_d    = vhold_q;
      idle_cnt_d = idle_cnt_q;
      out0_d     = out0_q;
      out1_d     = out1_q;
      out2_d     = out2_q;
      out3_d     = out3_q;
      validout_d = 4'b0000;

      case (state_q)
         EMPTY: begin
            if (beat) begin
               hold0_d    = in0;
               hold1_d    = in1;
               vhold_d    = validin;
               idle_cnt_d = 4'd0;
               state_d    = HALF;
            end
         end
         HALF: begin
            if (beat) begin
               // A beat wins over a timeout landing on the same edge.
               out0_d     = vhold_q[0] ? hold0_q : '0;
               out1_d     = vhold_q[1] ? hold1_q : '0;
               out2_d     = validin[0] ? in0 : '0;
               out3_d     = validin[1] ? in1 : '0;
               validout_d = {validin, vhold_q};
               state_d    = EMPTY;
            end else if (idle_cnt_q == IDLE_LAST) begin
               out0_d     = vhold_q[0] ? hold0_q : '0;
               out1_d     = vhold_q[1] ? hold1_q : '0;
               out2_d     = '0;
               out3_d     = '0;
               validout_d = {2'b00, vhold_q};
               idle_cnt_d = 4'd0;
               state_d    = EMPTY;
            end else begin
               idle_cnt_d = idle_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   // State, hold and output registers; reset drops any held beat silently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= EMPTY;
         hold0_q    <= '0;
         hold1_q    <= '0;
         vhold_q    <= 2'b00;
         idle_cnt_q <= 4'd0;
         out0_q     <= '0;
         out1_q     <= '0;
         out2_q     <= '0;
         out3_q     <= '0;
         validout_q <= 4'b0000;
      end else begin
         state_q    <= state_d;
         hold0_q    <= hold0_d;
         hold1_q    <= hold1_d;
         vhold_q    <= vhold_d;
         idle_cnt_q <= idle_cnt_d;
         out0_q     <= out0_d;
         out1_q     <= out1_d;
         out2_q     <= out2_d;
         out3_q     <= out3_d;
         validout_q <= validout_d;
      end
   end

   assign out0     = out0_q;
   assign out1     = out1_q;
   assign out2     = out2_q;
   assign out3     = out3_q;
   assign validout = validout_q;
   assign pending  = (state_q == HALF);

endmodule

// File: tb/tb_demux2x4_unstripe.sv
// Testbench for demux2x4_unstripe: directed scenarios plus a randomized
// loopback through a behavioural model of the 4-to-2 lane mux.
module tb_demux2x4_unstripe;

   localparam int W        = 8;
   localparam int IDLE_MAX = 4;
   localparam int EW       = 4 * W + 4;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] in0 = '0;
   logic [W-1:0] in1 = '0;
   logic [1:0]   validin = 2'b00;
   logic [W-1:0] out0, out1, out2, out3;
   logic [3:0]   validout;
   logic         pending;

   always #5 clk = ~clk;

   demux2x4_unstripe #(.WIDTH(W), .IDLE_MAX(IDLE_MAX)) dut (
      .clk      (clk),
      .reset    (reset),
      .in0      (in0),
      .in1      (in1),
      .validin  (validin),
      .out0     (out0),
      .out1     (out1),
      .out2     (out2),
      .out3     (out3),
      .validout (validout),
      .pending  (pending)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];

   function automatic logic [EW-1:0] pack_word(input logic [3:0] v,
                                               input logic [W-1:0] o3, o2, o1, o0);
      return {v, o3, o2, o1, o0};
   endfunction

   // Whenever a word is announced it must be the oldest expected word.
   always @(negedge clk) begin
      if (!reset && validout != 4'b0000) begin
         logic [EW-1:0] got;
         got = {validout, out3, out2, out1, out0};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL monitor_unexpected: got %h required no word", got);
         end else begin
            logic [EW-1:0] want;
            want = exp_q.pop_front();
            if (got !== want) begin
               errors++;
               $display("FAIL monitor_word: got %h required %h", got, want);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Present one input cycle, wait for the sampling edge, return 1 time unit
   // after it so outputs of that edge are visible.
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] v);
      in0 = a;
      in1 = b;
      validin = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive($urandom_range(255), $urandom_range(255), 2'b00);
   endtask

   task automatic expect_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drained: got %0d words outstanding required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(posedge clk);
      #1;
      checks++;
      if ({validout, out3, out2, out1, out0, pending} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h %h %h %h %h p=%b required all 0",
                  validout, out3, out2, out1, out0, pending);
      end
      reset = 1'b0;
      idle(2);
      checks++;
      if (validout !== 4'b0000 || pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got v=%b p=%b required v=0000 p=0", validout, pending);
      end
   endtask

   task automatic test_basic_pairing();
      exp_q.push_back(pack_word(4'b1111, 8'h44, 8'h33, 8'h22, 8'h11));
      drive(8'h11, 8'h22, 2'b11);
      checks++;
      if (pending !== 1'b1 || validout !== 4'b0000) begin
         errors++;
         $display("FAIL basic_first_beat: got p=%b v=%b required p=1 v=0000", pending, validout);
      end
      drive(8'h33, 8'h44, 2'b11);
      checks++;
      if ({out0, out1, out2, out3} !== 32'h11223344 || validout !== 4'b1111 || pending !== 1'b0) begin
         errors++;
         $display("FAIL basic_word: got %h%h%h%h v=%b p=%b required 11223344 v=1111 p=0",
                  out0, out1, out2, out3, validout, pending);
      end
      idle(1);
      checks++;
      if (validout !== 4'b0000 || out0 !== 8'h11) begin
         errors++;
         $display("FAIL basic_one_cycle: got v=%b out0=%h required v=0000 out0=11", validout, out0);
      end
      expect_drained("basic");
   endtask

   task automatic test_idle_masking();
      exp_q.push_back(pack_word(4'b0111, 8'h00, 8'hCC, 8'hBB, 8'hAA));
      drive(8'hAA, 8'hBB, 2'b11);
      idle(2);
      drive(8'hCC, 8'h5A, 2'b01);
      checks++;
      if ({out0, out1, out2, out3} !== 32'hAABBCC00 || validout !== 4'b0111) begin
         errors++;
         $display("FAIL mask_word: got %h%h%h%h v=%b required AABBCC00 v=0111",
                  out0, out1, out2, out3, validout);
      end
      idle(IDLE_MAX + 2);
      expect_drained("mask");
   endtask

   task automatic test_timeout_flush();
      exp_q.push_back(pack_word(4'b0011, 8'h00, 8'h00, 8'h02, 8'h01));
      drive(8'h01, 8'h02, 2'b11);
      for (int i = 1; i < IDLE_MAX; i++) begin
         idle(1);
         checks++;
         if (pending !== 1'b1 || validout !== 4'b0000) begin
            errors++;
            $display("FAIL flush_early_idle%0d: got p=%b v=%b required p=1 v=0000", i, pending, validout);
         end
      end
      idle(1);
      checks++;
      if ({out0, out1, out2, out3} !== 32'h01020000 || validout !== 4'b0011 || pending !== 1'b0) begin
         errors++;
         $display("FAIL flush_word: got %h%h%h%h v=%b p=%b required 01020000 v=0011 p=0",
                  out0, out1, out2, out3, validout, pending);
      end
      idle(2);
      checks++;
      if (out0 !== 8'h01 || validout !== 4'b0000) begin
         errors++;
         $display("FAIL flush_hold: got out0=%h v=%b required out0=01 v=0000", out0, validout);
      end
      expect_drained("flush");
   endtask

   task automatic test_timeout_race();
      exp_q.push_back(pack_word(4'b1111, 8'hD4, 8'hC3, 8'hB2, 8'hA1));
      drive(8'hA1, 8'hB2, 2'b11);
      idle(IDLE_MAX - 1);
      checks++;
      if (pending !== 1'b1) begin
         errors++;
         $display("FAIL race_pending: got %b required 1", pending);
      end
      drive(8'hC3, 8'hD4, 2'b11);
      checks++;
      if (validout !== 4'b1111 || out2 !== 8'hC3) begin
         errors++;
         $display("FAIL race_word: got v=%b out2=%h required v=1111 out2=c3", validout, out2);
      end
      idle(IDLE_MAX + 1);
      expect_drained("race");
   endtask

   task automatic test_reset_mid();
      drive(8'h55, 8'h66, 2'b11);
      idle(0);
      validin = 2'b00;
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({validout, out3, out2, out1, out0, pending} !== '0) begin
         errors++;
         $display("FAIL reset_mid_async: got %h %h %h %h %h p=%b required all 0",
                  validout, out3, out2, out1, out0, pending);
      end
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back(pack_word(4'b1111, 8'hEE, 8'h99, 8'h88, 8'h77));
      drive(8'h77, 8'h88, 2'b11);
      drive(8'h99, 8'hEE, 2'b11);
      checks++;
      if ({out0, out1, out2, out3} !== 32'h778899EE) begin
         errors++;
         $display("FAIL reset_mid_word: got %h%h%h%h required 778899ee", out0, out1, out2, out3);
      end
      idle(IDLE_MAX + 1);
      expect_drained("reset_mid");
   endtask

   // Loopback: a 4-lane word leaves the mux as lanes 0/1 then lanes 2/3;
   // the unstriped word must equal the original with invalid lanes zeroed.
   task automatic test_loopback();
      for (int n = 0; n < 64; n++) begin
         logic [W-1:0] lane[4];
         logic [3:0]   v;
         logic [W-1:0] m[4];
         for (int k = 0; k < 4; k++) lane[k] = W'($urandom_range(255));
         v[1:0] = 2'($urandom_range(3, 1));
         v[3:2] = 2'($urandom_range(3, 1));
         for (int k = 0; k < 4; k++) m[k] = v[k] ? lane[k] : '0;
         exp_q.push_back(pack_word(v, m[3], m[2], m[1], m[0]));
         drive(lane[0], lane[1], v[1:0]);
         idle($urandom_range(IDLE_MAX - 1));
         drive(lane[2], lane[3], v[3:2]);
         idle($urandom_range(3));
      end
      idle(IDLE_MAX + 2);
      expect_drained("loopback");
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic_pairing();
      test_idle_masking();
      test_timeout_flush();
      test_timeout_race();
      test_reset_mid();
      test_loopback();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within bound");
      $fatal(1);
   end

endmodule
